// File: rtl/fft_tw_pkg.sv
// Shared definitions for the FFT twiddle sequencer.
// Holds the default geometry, the controller state enum and the helper that
// packs {stage, index} into a twiddle ROM address.
package fft_tw_pkg;

   localparam int unsigned NUM_STAGES   = 7;
   localparam int unsigned TW_PER_STAGE = 4;
   localparam int unsigned ADDR_W       = 5;
   localparam int unsigned DATA_W       = 16;
   localparam int unsigned STAGE_W      = 3;
   localparam int unsigned INDEX_W      = 2;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StHold,
      StDone
   } tw_state_e;

   function automatic logic [ADDR_W-1:0] tw_addr(input logic [STAGE_W-1:0] stage,
                                                 input logic [INDEX_W-1:0] index);
      return {stage, index};
   endfunction

endpackage

// File: rtl/fft_tw_negate.sv
// Combinational saturating two's-complement negate for twiddle words.
// The most negative value has no positive counterpart, so it maps to the
// most positive value instead of wrapping back onto itself.
//
// Ports:
//   din   in  DATA_W  twiddle word
//   dout  out DATA_W  -din, with the most negative value saturated
module fft_tw_negate #(
   parameter int unsigned DATA_W = fft_tw_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   always_comb begin
      dout = -din;
      if (din == MOST_NEG) begin
         dout = ~MOST_NEG;
      end
   end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Walks the twiddle ROM in stage order and presents each coefficient to the
// butterfly over a valid/ready handshake. Every coefficient takes one ISSUE
// cycle (address presented), one WAIT cycle (ROM read latency, data captured
// at its end) and at least one HOLD cycle (tw_valid high until accepted).
//
// Optional feature macro: FFT_TW_CONJ_EN. When defined, a sweep started with
// inverse = 1 emits saturated negated ROM words (conjugate twiddles); when
// undefined, inverse is ignored and ROM words pass through unchanged.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, inverse      sweep request and conjugate select (sampled in IDLE)
//   busy, done          sweep in progress / one-cycle completion pulse
//   rom_addr, rom_data  twiddle ROM address out, read data in (1-cycle latency)
//   tw_valid, tw_ready  coefficient handshake
//   tw_data, tw_stage, tw_index, tw_last  coefficient and its position
module fft_twiddle_sequencer #(
   parameter int unsigned NUM_STAGES   = fft_tw_pkg::NUM_STAGES,
   parameter int unsigned TW_PER_STAGE = fft_tw_pkg::TW_PER_STAGE,
   parameter int unsigned ADDR_W       = fft_tw_pkg::ADDR_W,
   parameter int unsigned DATA_W       = fft_tw_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              inverse,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              tw_valid,
   input  logic              tw_ready,
   output logic [DATA_W-1:0] tw_data,
   output logic [2:0]        tw_stage,
   output logic [1:0]        tw_index,
   output logic              tw_last
);

   import fft_tw_pkg::*;

   localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
   localparam logic [1:0] LAST_INDEX = 2'(TW_PER_STAGE - 1);

   tw_state_e         state_q, state_d;
   logic [2:0]        stage_q, stage_d;
   logic [1:0]        index_q, index_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0] tw_data_q, tw_data_d;
   logic [DATA_W-1:0] cap_data;
   logic              last_c;

`ifdef FFT_TW_CONJ_EN
   logic              inv_q;
   logic [DATA_W-1:0] neg_data;

   fft_tw_negate #(
      .DATA_W(DATA_W)
   ) u_negate (
      .din (rom_data),
      .dout(neg_data)
   );

   // inverse is latched with the accepted start and held for the whole sweep
   always_ff @(posedge clk) begin
      if (rst) begin
         inv_q <= 1'b0;
      end else if (state_q == StIdle && start) begin
         inv_q <= inverse;
      end
   end

   assign cap_data = inv_q ? neg_data : rom_data;
`else
   logic unused_inverse;
   assign unused_inverse = inverse;
   assign cap_data       = rom_data;
`endif

   assign last_c = (stage_q == LAST_STAGE) && (index_q == LAST_INDEX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         stage_q    <= '0;
         index_q    <= '0;
         rom_addr_q <= '0;
         tw_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         index_q    <= index_d;
         rom_addr_q <= rom_addr_d;
         tw_data_q  <= tw_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      index_d    = index_q;
      rom_addr_d = rom_addr_q;
      tw_data_d  = tw_data_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               stage_d    = '0;
               index_d    = '0;
               // address is loaded on entry so it is stable throughout ISSUE
               rom_addr_d = ADDR_W'(tw_addr(3'd0, 2'd0));
               state_d    = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            tw_data_d = cap_data;
            state_d   = StHold;
         end
         StHold: begin
            if (tw_ready) begin
               if (last_c) begin
                  state_d = StDone;
               end else begin
                  if (index_q == LAST_INDEX) begin
                     index_d = '0;
                     stage_d = stage_q + 3'd1;
                  end else begin
                     index_d = index_q + 2'd1;
                  end
                  rom_addr_d = ADDR_W'(tw_addr(stage_d, index_d));
                  state_d    = StIssue;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign tw_valid = (state_q == StHold);
   assign tw_last  = tw_valid && last_c;
   assign rom_addr = rom_addr_q;
   assign tw_data  = tw_data_q;
   assign tw_stage = stage_q;
   assign tw_index = index_q;

endmodule

// File: doc/fft_twiddle_sequencer.md
# fft_twiddle_sequencer

Controller that walks the imaginary-part twiddle ROM in FFT stage order and hands each coefficient to the butterfly datapath over a valid/ready handshake. It sits between the FFT stage controller (start/done) and the twiddle ROM (5-bit address, 16-bit synchronous read). It generates addresses packed as {stage[2:0], index[1:0]}, absorbs the ROM's one-cycle read latency, and holds each coefficient until the butterfly consumes it.

## Interface
- NUM_STAGES, 7, number of FFT stages sequenced; stage field 0..NUM_STAGES-1
- TW_PER_STAGE, 4, twiddles per stage; must be a power of two ≤ 4
- ADDR_W, 5, ROM address width = 3 stage bits + 2 index bits
- DATA_W, 16, twiddle word width, two's complement
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one full sweep; sampled only in IDLE
- inverse  in  1  sampled with start; selects conjugate output (used only with FFT_TW_CONJ_EN)
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse after the last twiddle is consumed
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr
- tw_valid  out  1  tw_data/tw_stage/tw_index are valid
- tw_ready  in  1  butterfly accepts the coefficient when tw_valid && tw_ready
- tw_data  out  DATA_W  twiddle coefficient
- tw_stage  out  3  stage of the current coefficient
- tw_index  out  2  index within the stage
- tw_last  out  1  high with tw_valid on the final coefficient of the sweep

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - On start, clear the stage/index counters and latch inverse; go to ISSUE.
  - start is ignored in every other state.
- ISSUE: rom_addr = {stage, index}; go to WAIT.
- WAIT: capture rom_data into tw_data, conditioned by the Configuration rule; go to HOLD.
- HOLD:
  - tw_valid = 1. tw_data, tw_stage, tw_index and tw_last stay stable until the handshake.
  - On the handshake: if tw_last, go to DONE. Otherwise increment index; when index wraps at TW_PER_STAGE-1, clear index and increment stage. Then go to ISSUE.
- DONE: done = 1 for exactly one cycle; go to IDLE.
- tw_last = (stage == NUM_STAGES-1) && (index == TW_PER_STAGE-1).
- Counters never exceed their ranges. ROM addresses outside {stage < NUM_STAGES, index < TW_PER_STAGE} are never issued.
- rst in any state, including mid-sweep with tw_valid high, forces IDLE on the next edge. The pending coefficient is dropped and no done pulse is produced.
- tw_ready while tw_valid = 0 has no effect.

## Timing
- Reset values: busy 0, done 0, tw_valid 0, tw_last 0, rom_addr 0, tw_data 0, tw_stage 0, tw_index 0, state IDLE.
- Start at edge E0 → ISSUE in the cycle after E0 → first tw_valid 3 cycles after the start edge.
- Each coefficient is preceded by one ISSUE and one WAIT cycle: at most one coefficient every 3 cycles.
- Full sweep with tw_ready held high: 3·NUM_STAGES·TW_PER_STAGE + 1 cycles from start to the done pulse (85 with defaults).
- Back-pressure stretches HOLD indefinitely with no data loss.
- done and tw_valid are never high together.

## Configuration
- FFT_TW_CONJ_EN defined:
  - If the latched inverse = 1, tw_data = −rom_data (two's-complement negate), with 16'h8000 saturated to 16'h7FFF.
  - If inverse = 0, rom_data passes through unchanged.
- FFT_TW_CONJ_EN undefined: the inverse port is present but ignored, and tw_data = rom_data always.

## Structure
- Package fft_tw_pkg:
  - state enum
  - NUM_STAGES, TW_PER_STAGE, ADDR_W, DATA_W defaults
  - function tw_addr(stage, index) returning the packed address
- One sub-module, fft_tw_negate: combinational saturating negate. Instantiated only under FFT_TW_CONJ_EN.

## Test plan
- Reset, then start with tw_ready = 1 and a ROM model holding the production contents:
  - 28 coefficients in order, addresses 0x00..0x1B
  - tw_data at address 0x05 = 16'hFF00, at 0x0F = 16'hFF13, at 0x1B = 16'hFFDA
  - done 85 cycles after start; tw_last only on stage 6, index 3
- tw_ready low for 10 cycles on stage 2, index 1:
  - tw_data holds 16'hFF4A and tw_valid stays high throughout
  - sweep resumes in order; done is delayed by exactly 10 cycles
- start pulsed again while busy: ignored; exactly 28 handshakes and one done pulse.
- rst asserted during HOLD of stage 3: the next cycle shows all outputs at reset values; a new start replays from address 0x00.
- FFT_TW_CONJ_EN defined, inverse = 1:
  - address 0x05 yields 16'h0100 and address 0x09 yields 16'h00B6
  - a ROM model word of 16'h8000 yields 16'h7FFF
- FFT_TW_CONJ_EN undefined, inverse = 1: address 0x05 yields 16'hFF00.
